// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, reorders nothing (in-order memory),
// and presents filled entries to decode. Optional same-cycle response bypass: IFETCH_QUEUE_BYPASS_EN.
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = 8;
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);

    logic [31:0]   pc;
    logic [AW:0]   head, fill, tail;
    logic [31:0]   e_pc   [DEPTH];
    logic [31:0]   e_data [DEPTH];
    logic [DW-1:0] drop_cnt;
    logic [31:0]   last_instr, last_pc;

    logic [AW:0]   reserved, pending;
    logic [AW-1:0] head_idx, fill_idx, tail_idx;
    logic          head_filled, rsp_fill, rsp_drop, rsp_any, bypass, pop, req_fire;

    // head..fill are filled entries, fill..tail are issued but unanswered
    assign reserved    = tail - head;
    assign pending     = tail - fill;
    assign head_idx    = head[AW-1:0];
    assign fill_idx    = fill[AW-1:0];
    assign tail_idx    = tail[AW-1:0];
    assign head_filled = (head != fill);

    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_fill = imem_rsp_valid && (drop_cnt == '0) && (pending != '0);
    assign rsp_any  = imem_rsp_valid && ((drop_cnt != '0) || (pending != '0));

`ifdef IFETCH_QUEUE_BYPASS_EN
    assign bypass = rsp_fill && !head_filled && !redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = !rst && (head_filled || bypass);
    assign out_pc    = (head_filled || bypass) ? e_pc[head_idx] : last_pc;
    assign out_instr = head_filled ? e_data[head_idx] : (bypass ? imem_rsp_data : last_instr);

    assign imem_req_valid = !rst && !redirect_valid && (reserved < FULL);
    assign imem_req_addr  = pc;

    assign pop      = out_valid && out_ready;
    assign req_fire = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            head       <= '0;
            fill       <= '0;
            tail       <= '0;
            drop_cnt   <= '0;
            last_instr <= '0;
            last_pc    <= '0;
        end else begin
            if (out_valid) begin
                last_instr <= out_instr;
                last_pc    <= out_pc;
            end
            if (redirect_valid) begin
                // every outstanding request, including one answered right now, must be discarded
                pc       <= {redirect_pc[31:2], 2'b00};
                head     <= '0;
                fill     <= '0;
                tail     <= '0;
                drop_cnt <= drop_cnt + DW'(pending) - DW'(rsp_any);
            end else begin
                if (req_fire) begin
                    pc   <= pc + 32'd4;
                    tail <= tail + PTR_ONE;
                end
                if (rsp_drop) drop_cnt <= drop_cnt - DW'(1);
                if (rsp_fill) fill <= fill + PTR_ONE;
                if (pop)      head <= head + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid) begin
            if (req_fire) e_pc[tail_idx] <= pc;
            if (rsp_fill && !(bypass && out_ready)) e_data[fill_idx] <= imem_rsp_data;
        end
    end

endmodule
